// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer and the forwarding unit.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned TMR_W      = 16;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERR
    } ctrl_state_e;

    // Address equality is passed in so the helper stays independent of REG_AW.
    function automatic logic hazard_match(input logic rd, input logic wr, input logic addr_eq);
        return rd & wr & addr_eq;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and latches a sticky timeout error.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TMO = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    output logic expire_o,
    output logic mem_err_o
);

    localparam logic [TMR_W-1:0] TMO = TMR_W'(MEM_TMO);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    // Timer restarts whenever the wait is broken; expiry fires on the MEM_TMO-th wait cycle.
    always_comb begin
        timer_d  = '0;
        expire_o = 1'b0;
        if (wait_i) begin
            timer_d  = timer_q + TMR_W'(1);
            expire_o = (timer_d == TMO);
        end
        err_d = err_q | expire_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign mem_err_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core with saturating statistics.
// Build option: define FORWARD_EN when the EX/MEM/WB bypass exists (only load-use stalls).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned MEM_TMO = 255,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg1_read,
    input  logic              id_reg2_read,
    input  logic [REG_AW-1:0] id_reg1_addr,
    input  logic [REG_AW-1:0] id_reg2_addr,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_write_addr,
    input  logic              ex_dm_read,
    input  logic              ex_branch_tkn,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_addr,
    input  logic              dm_req,
    input  logic              dm_ack,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_err
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_wait, tmr_expire, branch_ev, raw_haz;

    logic ex_hit, mem_hit, wb_hit;
    assign ex_hit  = hazard_match(id_reg1_read, ex_reg_write,  id_reg1_addr == ex_write_addr)
                   | hazard_match(id_reg2_read, ex_reg_write,  id_reg2_addr == ex_write_addr);
    assign mem_hit = hazard_match(id_reg1_read, mem_reg_write, id_reg1_addr == mem_write_addr)
                   | hazard_match(id_reg2_read, mem_reg_write, id_reg2_addr == mem_write_addr);
    assign wb_hit  = hazard_match(id_reg1_read, wb_reg_write,  id_reg1_addr == wb_write_addr)
                   | hazard_match(id_reg2_read, wb_reg_write,  id_reg2_addr == wb_write_addr);

`ifdef FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = mem_hit | wb_hit;
    assign raw_haz    = ex_dm_read & ex_hit;
`else
    logic unused_fwd;
    assign unused_fwd = ex_dm_read;
    assign raw_haz    = ex_hit | mem_hit | wb_hit;
`endif

    assign mem_wait = (state_q != ST_ERR) & dm_req & ~dm_ack;

    mem_wait_timer #(
        .MEM_TMO (MEM_TMO)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .wait_i    (mem_wait),
        .expire_o  (tmr_expire),
        .mem_err_o (mem_err)
    );

    always_comb begin
        state_d     = state_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        branch_ev   = 1'b0;
        if (state_q == ST_ERR || mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            if (state_q != ST_ERR) begin
                state_d = tmr_expire ? ST_ERR : ST_MEM_WAIT;
            end
        end else begin
            // Release cycle (or plain run): branch beats hazard, whose ID instr is flushed anyway.
            state_d = ST_RUN;
            if (ex_branch_tkn) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                branch_ev  = 1'b1;
            end else if (raw_haz) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
        if (rst) begin
            state_d     = ST_RUN;
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_stall  = 1'b0;
            idex_flush  = 1'b0;
            exmem_stall = 1'b0;
            branch_ev   = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_ev && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model, plus directed scenarios.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 5;
    localparam int TMO  = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_reg1_read, id_reg2_read;
    logic [AW-1:0] id_reg1_addr, id_reg2_addr;
    logic          ex_reg_write, ex_dm_read, ex_branch_tkn;
    logic [AW-1:0] ex_write_addr;
    logic          mem_reg_write, wb_reg_write;
    logic [AW-1:0] mem_write_addr, wb_write_addr;
    logic          dm_req, dm_ack;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_err;

    int n_chk = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .REG_AW  (AW),
        .MEM_TMO (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_reg1_read   (id_reg1_read),
        .id_reg2_read   (id_reg2_read),
        .id_reg1_addr   (id_reg1_addr),
        .id_reg2_addr   (id_reg2_addr),
        .ex_reg_write   (ex_reg_write),
        .ex_write_addr  (ex_write_addr),
        .ex_dm_read     (ex_dm_read),
        .ex_branch_tkn  (ex_branch_tkn),
        .mem_reg_write  (mem_reg_write),
        .mem_write_addr (mem_write_addr),
        .wb_reg_write   (wb_reg_write),
        .wb_write_addr  (wb_write_addr),
        .dm_req         (dm_req),
        .dm_ack         (dm_ack),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_stall     (idex_stall),
        .idex_flush     (idex_flush),
        .exmem_stall    (exmem_stall),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: error flag, consecutive wait cycles, counters as plain integers.
    bit m_valid = 0;
    bit m_err   = 0;
    int m_wait  = 0;
    int m_scnt  = 0;
    int m_fcnt  = 0;

    function automatic bit model_haz();
        bit            rd[2];
        logic [AW-1:0] ra[2];
        bit            pw[3];
        logic [AW-1:0] pa[3];
        bit            hit = 0;
        rd[0] = id_reg1_read;  ra[0] = id_reg1_addr;
        rd[1] = id_reg2_read;  ra[1] = id_reg2_addr;
        pw[0] = ex_reg_write;  pa[0] = ex_write_addr;
        pw[1] = mem_reg_write; pa[1] = mem_write_addr;
        pw[2] = wb_reg_write;  pa[2] = wb_write_addr;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 3; p++) begin
`ifdef FORWARD_EN
                if (p == 0 && ex_dm_read && rd[s] && pw[p] && ra[s] == pa[p]) hit = 1;
`else
                if (rd[s] && pw[p] && ra[s] == pa[p]) hit = 1;
`endif
            end
        end
        return hit;
    endfunction

    always @(negedge clk) begin
        bit       wt, fr, br, hz;
        bit [5:0] exp_s;
        wt = !m_err && dm_req && !dm_ack;
        fr = m_err || wt;
        br = !fr && ex_branch_tkn;
        hz = !fr && !br && model_haz();
        if (rst) begin
            fr = 0; br = 0; hz = 0; wt = 0;
        end
        // order: pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall
        exp_s = {fr | hz, fr | hz, br, fr, br | hz, fr};
        if (m_valid || rst) begin
            chk("strobes", {26'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}, {26'd0, exp_s});
        end
        if (m_valid) begin
            chk("stall_cnt", stall_cnt, m_scnt);
            chk("flush_cnt", flush_cnt, m_fcnt);
            chk("mem_err", mem_err, m_err);
        end
        if (rst) begin
            m_valid = 1; m_err = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
        end else if (m_valid) begin
            if (exp_s[5] && m_scnt < CMAX) m_scnt++;
            if (br && m_fcnt < CMAX) m_fcnt++;
            if (wt) begin
                m_wait++;
                if (m_wait == TMO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
    end

    task automatic clr();
        id_reg1_read = 0; id_reg2_read = 0; id_reg1_addr = '0; id_reg2_addr = '0;
        ex_reg_write = 0; ex_write_addr = '0; ex_dm_read = 0; ex_branch_tkn = 0;
        mem_reg_write = 0; mem_write_addr = '0; wb_reg_write = 0; wb_write_addr = '0;
        dm_req = 0; dm_ack = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clr();
        nxt();
        rst = 0;
    endtask

    initial begin
        bit burst = 0;
        rst = 1;
        clr();
        nxt();
        nxt();
        rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_pc_stall", pc_stall, 0);

        // Load/ALU producer in EX advancing EX->MEM->WB while ID keeps reading r3
        nxt();
        do_reset();
        id_reg1_read = 1; id_reg1_addr = 5'd3;
        ex_reg_write = 1; ex_write_addr = 5'd3; ex_dm_read = 1;
        @(negedge clk);
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_exmem_stall", exmem_stall, 0);
        nxt();
        ex_reg_write = 0; ex_dm_read = 0; mem_reg_write = 1; mem_write_addr = 5'd3;
        nxt();
        mem_reg_write = 0; wb_reg_write = 1; wb_write_addr = 5'd3;
        nxt();
        wb_reg_write = 0;
        @(negedge clk);
`ifdef FORWARD_EN
        chk("lu_stall_cnt", stall_cnt, 1);
`else
        chk("raw_stall_cnt", stall_cnt, 3);
`endif
        chk("lu_done_pc_stall", pc_stall, 0);

        // Taken branch with simultaneous hazard
        nxt();
        do_reset();
        ex_branch_tkn = 1; ex_dm_read = 1; ex_reg_write = 1; ex_write_addr = 5'd5;
        id_reg2_read = 1; id_reg2_addr = 5'd5;
        @(negedge clk);
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_idex_flush", idex_flush, 1);
        chk("br_pc_stall", pc_stall, 0);
        nxt();
        clr();
        @(negedge clk);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 0);
        chk("br_one_cycle", ifid_flush, 0);

        // Four wait cycles with a pending branch, released on ack
        nxt();
        do_reset();
        dm_req = 1; ex_branch_tkn = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mw_exmem_stall", exmem_stall, 1);
            chk("mw_no_flush", ifid_flush, 0);
            nxt();
        end
        dm_ack = 1;
        @(negedge clk);
        chk("mw_release", pc_stall, 0);
        chk("mw_branch_after", ifid_flush, 1);
        nxt();
        clr();
        @(negedge clk);
        chk("mw_stall_cnt", stall_cnt, 4);
        chk("mw_flush_cnt", flush_cnt, 1);

        // Timeout: ack never arrives
        nxt();
        do_reset();
        dm_req = 1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("tmo_err_pending", mem_err, 0);
            nxt();
        end
        dm_req = 0;
        @(negedge clk);
        chk("tmo_mem_err", mem_err, 1);
        chk("tmo_freeze_pc", pc_stall, 1);
        chk("tmo_freeze_exmem", exmem_stall, 1);
        nxt();
        rst = 1;
        @(negedge clk);
        chk("tmo_rst_strobe", pc_stall, 0);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("tmo_after_err", mem_err, 0);
        chk("tmo_after_scnt", stall_cnt, 0);
        chk("tmo_after_pc", pc_stall, 0);

        // Stall counter saturation
        nxt();
        do_reset();
        id_reg1_read = 1; id_reg1_addr = 5'd1;
        ex_reg_write = 1; ex_write_addr = 5'd1; ex_dm_read = 1;
        repeat (CMAX - 1) nxt();
        @(negedge clk);
        chk("sat_pre", stall_cnt, CMAX - 1);
        repeat (3) nxt();
        @(negedge clk);
        chk("sat_hold", stall_cnt, CMAX);

        // Randomized traffic
        nxt();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            id_reg1_read = $urandom_range(0, 1); id_reg1_addr = AW'($urandom_range(0, 3));
            id_reg2_read = $urandom_range(0, 1); id_reg2_addr = AW'($urandom_range(0, 3));
            ex_reg_write = $urandom_range(0, 1); ex_write_addr = AW'($urandom_range(0, 3));
            ex_dm_read = $urandom_range(0, 1);
            ex_branch_tkn = ($urandom_range(0, 5) == 0);
            mem_reg_write = $urandom_range(0, 1); mem_write_addr = AW'($urandom_range(0, 3));
            wb_reg_write = $urandom_range(0, 1); wb_write_addr = AW'($urandom_range(0, 3));
            if (!burst && $urandom_range(0, 19) == 0) burst = 1;
            dm_req = burst | ($urandom_range(0, 7) == 0);
            dm_ack = burst ? ($urandom_range(0, 6) == 0) : $urandom_range(0, 1);
            if (burst && dm_ack) burst = 0;
            nxt();
        end
        clr();
        rst = 0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
